// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative divider: RV32M funct3 op selects and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_unit_pkg;

   localparam logic [2:0] DIV_F3_DIV  = 3'b100;
   localparam logic [2:0] DIV_F3_DIVU = 3'b101;
   localparam logic [2:0] DIV_F3_REM  = 3'b110;
   localparam logic [2:0] DIV_F3_REMU = 3'b111;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // DIV and REM interpret operands as two's complement
   function automatic logic div_is_signed(input logic [2:0] f3);
      return (f3 == DIV_F3_DIV) || (f3 == DIV_F3_REM);
   endfunction

   // REM and REMU return the remainder instead of the quotient
   function automatic logic div_is_rem(input logic [2:0] f3);
      return (f3 == DIV_F3_REM) || (f3 == DIV_F3_REMU);
   endfunction

endpackage

// File: rtl/div_unit_sign_fix.sv
// Applies sign correction to the magnitude quotient/remainder and selects the op's result.
// Latency: combinational.
// Backpressure: none.
module div_sign_fix
   import div_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] rem_i,
   input  logic            q_neg_i,
   input  logic            r_neg_i,
   input  logic [2:0]      op_i,
   output logic [XLEN-1:0] res_o
);

   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;

   // two's complement negation modulo 2^XLEN, then pick quotient or remainder
   always_comb begin
      quo_fix = q_neg_i ? (~quo_i + {{(XLEN-1){1'b0}}, 1'b1}) : quo_i;
      rem_fix = r_neg_i ? (~rem_i + {{(XLEN-1){1'b0}}, 1'b1}) : rem_i;
      res_o   = div_is_rem(op_i) ? rem_fix : quo_fix;
   end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU in the Execute stage.
// Latency: 33 cycles request-to-valid (1 cycle for divide-by-zero and signed overflow).
// Backpressure: none; DIV_validE pulses once and the hazard unit holds the stall until then.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            RtypedivE,
   input  logic [2:0]      funct3E,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic            killE,
   output logic            DIV_validE,
   output logic [XLEN-1:0] DivResultE,
   output logic            div_busyE
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      state_q;
   logic [2:0]      op_q;
   logic            q_neg_q;
   logic            r_neg_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] dvs_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0] res_q;
   logic            valid_q;
   logic            busy_q;

   logic            sgn;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] special_res;

   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;
   logic            ge;
   logic [XLEN-1:0] step_quo;
   logic [XLEN-1:0] step_rem;
   logic [XLEN-1:0] fixed_res;

   // operand decode for the accept edge: magnitudes, signs and the two short-circuit cases
   always_comb begin
      sgn         = div_is_signed(funct3E);
      a_neg       = sgn & SrcAE[XLEN-1];
      b_neg       = sgn & SrcBE[XLEN-1];
      mag_a       = a_neg ? (~SrcAE + {{(XLEN-1){1'b0}}, 1'b1}) : SrcAE;
      mag_b       = b_neg ? (~SrcBE + {{(XLEN-1){1'b0}}, 1'b1}) : SrcBE;
      div_zero    = (SrcBE == '0);
      ovf         = sgn & (SrcAE == MIN_NEG) & (SrcBE == '1);
      special_res = '0;
      if (div_zero) begin
         special_res = div_is_rem(funct3E) ? SrcAE : '1;
      end else if (ovf) begin
         special_res = div_is_rem(funct3E) ? '0 : MIN_NEG;
      end
   end

   // one restoring step: shift {r,q} left, subtract divisor when it fits (XLEN+1-bit compare)
   always_comb begin
      shifted  = {rem_q, quo_q[XLEN-1]};
      diff     = shifted - {1'b0, dvs_q};
      ge       = (shifted >= {1'b0, dvs_q});
      step_rem = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      step_quo = {quo_q[XLEN-2:0], ge};
   end

   div_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .quo_i   (step_quo),
      .rem_i   (step_rem),
      .q_neg_i (q_neg_q),
      .r_neg_i (r_neg_q),
      .op_i    (op_q),
      .res_o   (fixed_res)
   );

   // sequencing FSM with registered result, valid and busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DIV_IDLE;
         op_q    <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               if (RtypedivE && !killE) begin
                  op_q <= funct3E;
                  if (div_zero || ovf) begin
                     res_q   <= special_res;
                     valid_q <= 1'b1;
                     state_q <= DIV_DONE;
                  end else begin
                     quo_q   <= mag_a;
                     dvs_q   <= mag_b;
                     rem_q   <= '0;
                     cnt_q   <= '0;
                     q_neg_q <= a_neg ^ b_neg;
                     r_neg_q <= a_neg;
                     busy_q  <= 1'b1;
                     state_q <= DIV_CALC;
                  end
               end
            end
            DIV_CALC: begin
               if (killE) begin
                  busy_q  <= 1'b0;
                  state_q <= DIV_IDLE;
               end else begin
                  quo_q <= step_quo;
                  rem_q <= step_rem;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_STEP) begin
                     res_q   <= fixed_res;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= DIV_DONE;
                  end
               end
            end
            DIV_DONE: begin
               // leave unconditionally; no re-accept while the result is presented
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= DIV_IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= DIV_IDLE;
            end
         endcase
      end
   end

   // a kill during DONE suppresses the pulse that is already registered
   assign DIV_validE = valid_q & ~killE;
   assign DivResultE = res_q;
   assign div_busyE  = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results popped on each valid pulse.
// Latency: checks 33-cycle normal and 1-cycle special-case response.
// Backpressure: n/a.
module tb_div_unit;

   localparam logic [2:0] F_DIV  = 3'b100;
   localparam logic [2:0] F_DIVU = 3'b101;
   localparam logic [2:0] F_REM  = 3'b110;
   localparam logic [2:0] F_REMU = 3'b111;

   logic        clk;
   logic        rst_n;
   logic        RtypedivE;
   logic [2:0]  funct3E;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        killE;
   logic        DIV_validE;
   logic [31:0] DivResultE;
   logic        div_busyE;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_pulses = 0;
   int pulse_cyc = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_res;

   div_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RtypedivE  (RtypedivE),
      .funct3E    (funct3E),
      .SrcAE      (SrcAE),
      .SrcBE      (SrcBE),
      .killE      (killE),
      .DIV_validE (DIV_validE),
      .DivResultE (DivResultE),
      .div_busyE  (div_busyE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard pop on every valid pulse, sampled mid-cycle
   always @(negedge clk) begin
      logic [31:0] e;
      if (DIV_validE === 1'b1) begin
         n_pulses++;
         pulse_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse: got result %h with empty scoreboard", DivResultE);
         end else begin
            e = exp_q.pop_front();
            if (DivResultE !== e) begin
               failures++;
               $display("FAIL result: got %h expected %h (cycle %0d)", DivResultE, e, cyc);
            end
         end
      end
   end

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic sgn;
      logic rem;
      sgn = (f3 == F_DIV) || (f3 == F_REM);
      rem = f3[1];
      if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
      if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return rem ? (a % b) : (a / b);
   endfunction

   task automatic wait_pulse(input int p0, input string name);
      for (int i = 0; i < 60 && n_pulses == p0; i++) begin
         @(posedge clk);
         #1;
      end
      if (n_pulses == p0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: no valid pulse within 60 cycles", name);
      end
   endtask

   task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
      int c0;
      int p0;
      @(posedge clk);
      #1;
      RtypedivE = 1'b1;
      funct3E   = f3;
      SrcAE     = a;
      SrcBE     = b;
      exp_q.push_back(exp);
      c0 = cyc;
      p0 = n_pulses;
      @(posedge clk);
      #1;
      RtypedivE = 1'b0;
      SrcAE     = $urandom;
      SrcBE     = $urandom;
      funct3E   = 3'($urandom_range(4, 7));
      if (exp_lat == 33) begin
         checks++;
         if (div_busyE !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy: got %b expected 1", name, div_busyE);
         end
      end
      wait_pulse(p0, name);
      if (n_pulses != p0) begin
         checks++;
         if (pulse_cyc - c0 != exp_lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected %0d", name, pulse_cyc - c0, exp_lat);
         end
      end
      checks++;
      if (DivResultE !== exp || DIV_validE !== 1'b0) begin
         failures++;
         $display("FAIL %s_hold: got %h valid %b expected %h valid 0", name, DivResultE, DIV_validE, exp);
      end
      last_res = exp;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; RtypedivE = 1'b0; funct3E = 3'd0; SrcAE = '0; SrcBE = '0; killE = 1'b0;
      #3;
      checks++;
      if (DIV_validE !== 1'b0 || div_busyE !== 1'b0 || DivResultE !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: valid %b busy %b result %h expected 0 0 0", DIV_validE, div_busyE, DivResultE);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      last_res = 32'd0;
      // idle with request low must stay quiet
      SrcAE = 32'd5; SrcBE = 32'd0; funct3E = F_DIV;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (n_pulses != 0 || div_busyE !== 1'b0) begin
         failures++;
         $display("FAIL idle_quiet: pulses %0d busy %b expected 0 0", n_pulses, div_busyE);
      end
   endtask

   task automatic test_basic();
      run_div(F_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
      run_div(F_REMU, 32'd100, 32'd7, 32'd2,  33, "remu_100_7");
   endtask

   task automatic test_signs();
      run_div(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
      run_div(F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
      run_div(F_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
      run_div(F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1,         33, "rem_7_m2");
   endtask

   task automatic test_special();
      run_div(F_DIV,  32'h1234, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
      run_div(F_REMU, 32'h1234, 32'd0, 32'h1234,      1, "remu_by0");
      run_div(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
      run_div(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         logic [31:0] b;
         int          lat;
         f3 = 3'($urandom_range(4, 7));
         a  = $urandom;
         b  = (i == 0) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom);
         lat = (b == 32'd0) ? 1 : 33;
         run_div(f3, a, b, model(f3, a, b), lat, "random");
      end
   endtask

   task automatic test_back_to_back();
      int  p0;
      int  pc1;
      logic hold_ok;
      @(posedge clk);
      #1;
      RtypedivE = 1'b1; funct3E = F_DIVU; SrcAE = 32'd50; SrcBE = 32'd5;
      exp_q.push_back(32'd10);
      exp_q.push_back(32'd2);
      p0 = n_pulses;
      @(posedge clk);
      #1;
      SrcAE = 32'd9; SrcBE = 32'd4;
      wait_pulse(p0, "b2b_first");
      pc1 = pulse_cyc;
      // request held through DONE must not be accepted; drop for one cycle then re-issue
      RtypedivE = 1'b0;
      @(posedge clk);
      #1;
      RtypedivE = 1'b1;
      p0 = n_pulses;
      @(posedge clk);
      #1;
      RtypedivE = 1'b0; SrcAE = $urandom; SrcBE = $urandom;
      hold_ok = 1'b1;
      for (int i = 0; i < 60 && n_pulses == p0; i++) begin
         if (DIV_validE !== 1'b1 && DivResultE !== 32'd10) hold_ok = 1'b0;
         @(posedge clk);
         #1;
      end
      checks++;
      if (!hold_ok) begin
         failures++;
         $display("FAIL b2b_hold: result left 10 between pulses");
      end
      checks++;
      if (n_pulses == p0 || pulse_cyc - pc1 != 35) begin
         failures++;
         $display("FAIL b2b_spacing: got %0d cycles expected 35", pulse_cyc - pc1);
      end
      last_res = 32'd2;
   endtask

   task automatic test_kill();
      int p0;
      @(posedge clk);
      #1;
      RtypedivE = 1'b1; funct3E = F_DIVU; SrcAE = 32'd77; SrcBE = 32'd5;
      p0 = n_pulses;
      @(posedge clk);
      #1;
      RtypedivE = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      killE = 1'b1;
      @(posedge clk);
      #1;
      killE = 1'b0;
      checks++;
      if (div_busyE !== 1'b0) begin
         failures++;
         $display("FAIL kill_busy: got %b expected 0", div_busyE);
      end
      repeat (45) @(posedge clk);
      #1;
      checks++;
      if (n_pulses != p0 || DivResultE !== last_res) begin
         failures++;
         $display("FAIL kill_quiet: pulses %0d result %h expected %0d %h", n_pulses - p0, DivResultE, 0, last_res);
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      @(posedge clk);
      #1;
      RtypedivE = 1'b1; funct3E = F_DIVU; SrcAE = 32'd1000; SrcBE = 32'd7;
      p0 = n_pulses;
      @(posedge clk);
      #1;
      RtypedivE = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (DIV_validE !== 1'b0 || div_busyE !== 1'b0 || DivResultE !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid: valid %b busy %b result %h expected 0 0 0", DIV_validE, div_busyE, DivResultE);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      last_res = 32'd0;
      repeat (45) @(posedge clk);
      #1;
      checks++;
      if (n_pulses != p0 || DivResultE !== 32'd0) begin
         failures++;
         $display("FAIL reset_release: pulses %0d result %h expected 0 0", n_pulses - p0, DivResultE);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_special();
      test_back_to_back();
      test_kill();
      test_reset_mid();
      test_random();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d results never produced, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider for the RV32M divide group (DIV, DIVU, REM, REMU). It sits in the Execute stage alongside the ALU and answers the hazard unit's divide-stall handshake. While a divide occupies E, the divider computes and holds `DIV_validE` low, so the hazard unit keeps `div_stallE` asserted. It raises `DIV_validE` for exactly one cycle with the final result, which releases the pipeline. The block is compiled only under `ENABLE_MUL_DIV_SUPPORT`.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `CNT_W`, 6: iteration counter width; must hold `XLEN`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `RtypedivE`  in  1  a divide-group instruction is in E; the same signal feeds the hazard unit.
- `funct3E`  in  3  operation select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcAE`  in  XLEN  dividend, taken after forwarding.
- `SrcBE`  in  XLEN  divisor, taken after forwarding.
- `killE`  in  1  abort the operation in flight; return to IDLE.
- `DIV_validE`  out  1  result valid; one-cycle pulse.
- `DivResultE`  out  XLEN  quotient or remainder; holds its value until the next accept.
- `div_busyE`  out  1  high in CALC.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: one restoring-division step per cycle.
  - DONE: result presented.
- IDLE → CALC on `RtypedivE & !killE`. On that edge the block latches:
  - operand magnitudes (absolute value for DIV/REM, raw for DIVU/REMU),
  - the op select,
  - `q_neg = signed & (a[31]^b[31])`,
  - `r_neg = signed & a[31]`.
  - It also sets `cnt = 0` and clears the partial remainder.
- IDLE → DONE directly, with no CALC, for these special cases:
  - Divisor zero: quotient = 0xFFFFFFFF; remainder = dividend, unmodified.
  - Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Each CALC step:
  - `{r,q} <<= 1`.
  - If `r >= d`: `r -= d` and `q[0] = 1`.
  - `cnt++`.
  - After `XLEN` steps, go to DONE.
- On the CALC → DONE edge, register the sign-corrected result into `DivResultE`:
  - quotient negated if `q_neg`,
  - remainder negated if `r_neg`,
  - REM/REMU select the remainder.
- DONE: `DIV_validE = 1`. Next edge → IDLE unconditionally. The E stage advances on that edge because the hazard unit drops the stall.
- IDLE does not re-accept in the DONE cycle. A back-to-back divide is accepted at the first IDLE cycle after that.
- `killE` in CALC or DONE → IDLE next edge, no valid pulse, `DivResultE` unchanged. `killE` has priority over all other transitions.
- Arithmetic: unsigned `XLEN+1`-bit compare/subtract. Negation is two's complement modulo 2^XLEN.

## Timing
- Reset values:
  - state IDLE,
  - `DIV_validE` 0,
  - `div_busyE` 0,
  - `DivResultE` 0,
  - all internal registers 0.
- Normal divide: request first seen in cycle 0, accept edge ends cycle 0, CALC covers cycles 1..32, DONE is cycle 33.
  - `DIV_validE` is high only in cycle 33.
  - This gives 33 stall cycles.
- Special case: DONE in cycle 1, `DIV_validE` high in cycle 1, 1 stall cycle.
- `DivResultE` is registered and stable throughout DONE and afterwards.
- Operands may change after the accept edge without effect.
- Reset asserted mid-CALC: immediate return to reset values. No valid pulse follows deassertion unless a new request arrives.
- `RtypedivE` low in IDLE: no state change. `funct3E` and operands are ignored.

## Structure
- Add the op encodings `DIV_F3_DIV`, `DIV_F3_DIVU`, `DIV_F3_REM` and `DIV_F3_REMU` to `config.vh` beside `ENABLE_MUL_DIV_SUPPORT`.
- Add the state encodings `DIV_IDLE`, `DIV_CALC` and `DIV_DONE` to `config.vh` as well.
- One combinational sub-module is natural: `div_sign_fix`. It takes the magnitude quotient/remainder, `q_neg`, `r_neg` and the op select, and produces the final result. All sequencing stays in `div_unit`.

## Test plan
- DIVU 100 / 7: `DIV_validE` pulses in cycle 33 only, with `DivResultE` = 14. Same operands with REMU → 2.
- Sign cases:
  - DIV -7 / 2 → 0xFFFFFFFD (-3).
  - REM -7 / 2 → 0xFFFFFFFF (-1).
  - DIV 7 / -2 → -3.
  - REM 7 / -2 → 1.
- Divisor 0 with dividend 0x1234 (each op checked separately):
  - DIV → 0xFFFFFFFF, valid in cycle 1.
  - REMU → 0x1234, valid in cycle 1.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in cycle 1. REM with the same operands → 0.
- Back-to-back divides, with operands changed immediately after the accept edge:
  - DIVU 50/5 then DIVU 9/4.
  - Valid pulses are 35 cycles apart, with results 10 then 2.
  - `DivResultE` holds 10 between the pulses.
- Abort and reset:
  - `killE` at CALC step 10 → IDLE, no pulse, `DivResultE` unchanged.
  - `rst_n` low mid-CALC → all outputs 0 asynchronously, and no pulse after release.
